// File: rtl/shift_add_multiplier_if.sv
// Operand/product handshake bundle between a requester (master) and the shift-add multiplier (slave).
interface shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier driving an external WIDTH-bit adder; product at accept+WIDTH+1, held under out_ready backpressure.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips CALC and presents product 0 one cycle after accept.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  shift_add_multiplier_if.slave    bus,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last_step;

  assign w_accept    = bus.in_valid && (r_state == S_IDLE);
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_ZERO_BYPASS_EN
  logic w_zero_op;
  assign w_zero_op = (bus.in_a == '0) || (bus.in_b == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m   <= bus.in_a;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            if (w_zero_op) begin
              r_q     <= '0;
              r_state <= S_DONE;
            end else begin
              r_q     <= bus.in_b;
              r_state <= S_CALC;
            end
`else
            r_q     <= bus.in_b;
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          // The adder carry lands in ACC's MSB; sum LSB shifts into Q as Q drops its consumed bit.
          r_acc <= {add_cout, add_sum[WIDTH-1:1]};
          r_q   <= {add_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last_step) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_CALC);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.product   = {r_acc, r_q};

  assign add_a   = r_acc;
  assign add_b   = r_m & {WIDTH{r_q[0]}};
  assign add_cin = 1'b0;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: models the external adder, runs a vector table, corner sequences and random operands.
module tb_shift_add_multiplier;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  int n_tests;
  int n_fail;

  shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External ripple-carry adder behaviour
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    int                 bp;
    logic [2*WIDTH-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit zero_path(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Called in the cycle after accept; returns cycles from accept to out_valid and busy cycles seen.
  task automatic wait_out(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int bp, input logic [2*WIDTH-1:0] exp);
    int lat;
    int bc;
    bit zb;
    zb = zero_path(a, b);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out(lat, bc);
    chk("latency", lat, zb ? 32'd1 : WIDTH + 1);
    chk("busy_cycles", bc, zb ? 32'd0 : WIDTH);
    chk("product", {24'd0, bus.product}, {24'd0, exp});
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_product", {24'd0, bus.product}, {24'd0, exp});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_dropped", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_after_done", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int bc;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{a: 4'd3,  b: 4'd5,  bp: 0, exp: 8'h0F};
    tbl[1] = '{a: 4'd15, b: 4'd15, bp: 3, exp: 8'hE1};
    tbl[2] = '{a: 4'd4,  b: 4'd4,  bp: 0, exp: 8'h10};
    tbl[3] = '{a: 4'd0,  b: 4'd9,  bp: 0, exp: 8'h00};
    tbl[4] = '{a: 4'd9,  b: 4'd0,  bp: 1, exp: 8'h00};
    tbl[5] = '{a: 4'd1,  b: 4'd15, bp: 2, exp: 8'h0F};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_product", {24'd0, bus.product}, 32'd0);
    chk("add_cin_zero", {31'd0, add_cin}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].bp, tbl[i].exp);
    end

    // Operands held valid during CALC must not be taken until in_ready returns
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'd2;
    bus.in_b      = 4'd6;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_a = 4'd7;
    bus.in_b = 4'd9;
    wait_out(lat, bc);
    chk("held_first_latency", lat, WIDTH + 1);
    chk("held_first_product", {24'd0, bus.product}, 32'h0C);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("held_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("held_second_busy", {31'd0, bus.busy}, 32'd1);
    wait_out(lat, bc);
    chk("held_second_product", {24'd0, bus.product}, 32'h3F);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd3;
    bus.in_b     = 4'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_product", {24'd0, bus.product}, 32'd0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      chk("rst_mid_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    do_op(4'd4, 4'd4, 0, 8'h10);

    // Random operands against plain integer multiplication
    for (int i = 0; i < 150; i++) begin
      ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      do_op(ra, rb, $urandom_range(0, 3), (2*WIDTH)'(int'(ra) * int'(rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
